reg_file_mp: RTL and testbench

Parametrised multi-port register file for the pipelined CPU datapath. Provides N_READ combinational read ports, two prioritised write ports (ALU writeback and load/auxiliary writeback), an optional hardwired-zero register 0, and optional same-cycle write-to-read bypass. It also keeps a per-register pending scoreboard, which the decode stage uses to detect RAW hazards against in-flight producers.

---
 rtl/reg_file_mp_if.sv | 34 +++
 rtl/reg_file_mp.sv | 66 ++++++
 tb/tb_reg_file_mp.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports, claim port and the raw busy vector.
// The master modport is the datapath side; the slave modport is the register file.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_READ = 2
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [N_READ*ADDR_W-1:0] raddr_i;
    logic [N_READ*DATA_W-1:0] rdata_o;
    logic [N_READ-1:0]        pend_o;
    logic                     we0_i;
    logic [ADDR_W-1:0]        waddr0_i;
    logic [DATA_W-1:0]        wdata0_i;
    logic                     we1_i;
    logic [ADDR_W-1:0]        waddr1_i;
    logic [DATA_W-1:0]        wdata1_i;
    logic                     claim_i;
    logic [ADDR_W-1:0]        claim_addr_i;
    logic [DEPTH-1:0]         busy_o;

    modport master (
        output raddr_i, we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i, wdata1_i,
               claim_i, claim_addr_i,
        input  rdata_o, pend_o, busy_o
    );

    modport slave (
        input  raddr_i, we0_i, waddr0_i, wdata0_i, we1_i, waddr1_i, wdata1_i,
               claim_i, claim_addr_i,
        output rdata_o, pend_o, busy_o
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with two prioritised write ports, optional zero register,
// optional same-cycle write-to-read bypass and a per-register pending scoreboard.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    reg_file_mp_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DEPTH-1:0]  w_pend_nxt;
    logic              w_we0;
    logic              w_we1;
    logic              w_claim;

    // Accesses to the hardwired zero register are squashed at the source.
    assign w_we0   = bus.we0_i   && !((ZERO_REG != 0) && (bus.waddr0_i == '0));
    assign w_we1   = bus.we1_i   && !((ZERO_REG != 0) && (bus.waddr1_i == '0));
    assign w_claim = bus.claim_i && !((ZERO_REG != 0) && (bus.claim_addr_i == '0));

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_we0) w_pend_nxt[bus.waddr0_i] = 1'b0;
        if (w_we1) w_pend_nxt[bus.waddr1_i] = 1'b0;
        // A claim applied after the clears lets the newly issued producer win.
        if (w_claim) w_pend_nxt[bus.claim_addr_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_pend <= '0;
        end else begin
            if (w_we0) r_mem[bus.waddr0_i] <= bus.wdata0_i;
            if (w_we1) r_mem[bus.waddr1_i] <= bus.wdata1_i;
            r_pend <= w_pend_nxt;
        end
    end

    assign bus.busy_o = r_pend;

    for (genvar k = 0; k < N_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit0;
        logic              w_hit1;
        logic              w_zero;

        assign w_ra   = bus.raddr_i[k*ADDR_W +: ADDR_W];
        assign w_zero = (ZERO_REG != 0) && (w_ra == '0);
        assign w_hit1 = (BYPASS != 0) && w_we1 && (bus.waddr1_i == w_ra);
        assign w_hit0 = (BYPASS != 0) && w_we0 && (bus.waddr0_i == w_ra);

        assign bus.rdata_o[k*DATA_W +: DATA_W] = w_zero ? '0 :
                                                 w_hit1 ? bus.wdata1_i :
                                                 w_hit0 ? bus.wdata0_i :
                                                 r_mem[w_ra];
        assign bus.pend_o[k] = !w_zero && !w_hit1 && !w_hit0 && r_pend[w_ra];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Drives a bypassing and a non-bypassing reg_file_mp with identical stimulus and checks
// both against a behavioural array model of the register file and scoreboard.
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] ra [NR];
    logic          we0 = 1'b0, we1 = 1'b0, claim = 1'b0;
    logic [AW-1:0] wa0 = '0, wa1 = '0, ca = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR)) ifb ();
    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR)) ifn ();

    assign ifb.raddr_i = {ra[1], ra[0]};
    assign ifn.raddr_i = {ra[1], ra[0]};
    assign ifb.we0_i = we0;  assign ifn.we0_i = we0;
    assign ifb.waddr0_i = wa0; assign ifn.waddr0_i = wa0;
    assign ifb.wdata0_i = wd0; assign ifn.wdata0_i = wd0;
    assign ifb.we1_i = we1;  assign ifn.we1_i = we1;
    assign ifb.waddr1_i = wa1; assign ifn.waddr1_i = wa1;
    assign ifb.wdata1_i = wd1; assign ifn.wdata1_i = wd1;
    assign ifb.claim_i = claim; assign ifn.claim_i = claim;
    assign ifb.claim_addr_i = ca; assign ifn.claim_addr_i = ca;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .BYPASS(1))
        u_byp (.clk_i(clk), .rst_i(rst), .bus(ifb));
    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1), .BYPASS(0))
        u_nob (.clk_i(clk), .rst_i(rst), .bus(ifn));

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_pend [DEPTH];

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic bit exp_pd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((we1 && wa1 == a) || (we0 && wa0 == a))) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic [DEPTH-1:0] exp_busy();
        logic [DEPTH-1:0] v;
        for (int i = 0; i < DEPTH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("%s byp rdata%0d a=%0d", tag, k, ra[k]),
                64'(ifb.rdata_o[k*DW +: DW]), 64'(exp_rd(ra[k], 1'b1)));
            chk($sformatf("%s nob rdata%0d a=%0d", tag, k, ra[k]),
                64'(ifn.rdata_o[k*DW +: DW]), 64'(exp_rd(ra[k], 1'b0)));
            chk($sformatf("%s byp pend%0d a=%0d", tag, k, ra[k]),
                64'(ifb.pend_o[k]), 64'(exp_pd(ra[k], 1'b1)));
            chk($sformatf("%s nob pend%0d a=%0d", tag, k, ra[k]),
                64'(ifn.pend_o[k]), 64'(exp_pd(ra[k], 1'b0)));
        end
        chk($sformatf("%s byp busy", tag), 64'(ifb.busy_o), 64'(exp_busy()));
        chk($sformatf("%s nob busy", tag), 64'(ifn.busy_o), 64'(exp_busy()));
    endtask

    // One rising edge: the model consumes the inputs that the DUTs sample, then inputs may change.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_pend[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_pend[wa1] = 1'b0; end
            if (claim && ca != 0) m_pend[ca] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; claim = 1'b0; rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 'x;
            m_pend[i] = 1'b0;
        end
        ra[0] = '0; ra[1] = '0;

        // Reset and sweep every address
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ra[0] = AW'(a); ra[1] = AW'(DEPTH - 1 - a);
            #1;
            check_all("reset_sweep");
        end

        // Same-cycle bypass vs registered read of r5
        ra[0] = 5; ra[1] = 6;
        we0 = 1'b1; wa0 = 5; wd0 = 32'h1234_5678;
        #1;
        chk("wr5 byp same", 64'(ifb.rdata_o[DW-1:0]), 64'h1234_5678);
        chk("wr5 nob same", 64'(ifn.rdata_o[DW-1:0]), 64'h0);
        check_all("wr5 same");
        step();
        idle();
        #1;
        chk("wr5 byp next", 64'(ifb.rdata_o[DW-1:0]), 64'h1234_5678);
        chk("wr5 nob next", 64'(ifn.rdata_o[DW-1:0]), 64'h1234_5678);
        check_all("wr5 next");

        // Write-port collision on r7
        ra[0] = 7; ra[1] = 5;
        we0 = 1'b1; wa0 = 7; wd0 = 32'hAAAA_AAAA;
        we1 = 1'b1; wa1 = 7; wd1 = 32'h5555_5555;
        #1;
        chk("wr7 byp same", 64'(ifb.rdata_o[DW-1:0]), 64'h5555_5555);
        check_all("wr7 same");
        step();
        idle();
        #1;
        chk("wr7 nob next", 64'(ifn.rdata_o[DW-1:0]), 64'h5555_5555);
        check_all("wr7 next");

        // Claim / write+claim / write on r9
        ra[0] = 9; ra[1] = 9;
        claim = 1'b1; ca = 9;
        step();
        chk("claim9 busy c1", 64'(ifb.busy_o[9]), 64'h1);
        chk("claim9 pend c1", 64'(ifn.pend_o[0]), 64'h1);
        we0 = 1'b1; wa0 = 9; wd0 = 32'h0000_0099;
        claim = 1'b1; ca = 9;
        #1;
        chk("claim9 byp pend wr", 64'(ifb.pend_o[0]), 64'h0);
        chk("claim9 nob pend wr", 64'(ifn.pend_o[0]), 64'h1);
        check_all("claim9 c2");
        step();
        chk("claim9 busy c2", 64'(ifn.busy_o[9]), 64'h1);
        claim = 1'b0;
        we0 = 1'b1; wa0 = 9; wd0 = 32'h0000_0199;
        #1;
        check_all("claim9 c3");
        step();
        idle();
        #1;
        chk("claim9 busy c3", 64'(ifb.busy_o[9]), 64'h0);
        chk("claim9 data", 64'(ifn.rdata_o[DW-1:0]), 64'h0000_0199);
        check_all("claim9 after");

        // Zero register ignores writes and claims
        ra[0] = 0; ra[1] = 0;
        we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 0; wd1 = 32'hFFFF_FFFF;
        claim = 1'b1; ca = 0;
        #1;
        chk("r0 byp same", 64'(ifb.rdata_o[DW-1:0]), 64'h0);
        chk("r0 byp pend same", 64'(ifb.pend_o[0]), 64'h0);
        step();
        idle();
        #1;
        chk("r0 rdata", 64'(ifb.rdata_o[DW-1:0]), 64'h0);
        chk("r0 pend", 64'(ifn.pend_o[0]), 64'h0);
        chk("r0 busy", 64'(ifb.busy_o[0]), 64'h0);
        check_all("r0 after");

        // Reset dominates a simultaneous write
        ra[0] = 3; ra[1] = 7;
        we0 = 1'b1; wa0 = 3; wd0 = 32'hDEAD_BEEF;
        claim = 1'b1; ca = 3;
        step();
        idle();
        #1;
        chk("r3 written", 64'(ifn.rdata_o[DW-1:0]), 64'hDEAD_BEEF);
        rst = 1'b1;
        we1 = 1'b1; wa1 = 3; wd1 = 32'h1111_2222;
        step();
        idle();
        #1;
        chk("r3 after rst byp", 64'(ifb.rdata_o[DW-1:0]), 64'h0);
        chk("r3 after rst nob", 64'(ifn.rdata_o[DW-1:0]), 64'h0);
        chk("busy after rst", 64'(ifb.busy_o), 64'h0);
        check_all("rst after");

        // Randomized traffic over a narrow address window to force collisions
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            we0   = $urandom_range(0, 1) == 1;
            we1   = $urandom_range(0, 2) == 0;
            claim = $urandom_range(0, 1) == 1;
            wa0   = AW'($urandom_range(0, 7));
            wa1   = AW'($urandom_range(0, 7));
            ca    = AW'($urandom_range(0, 7));
            wd0   = $urandom;
            wd1   = $urandom;
            ra[0] = AW'($urandom_range(0, 7));
            ra[1] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            #1;
            check_all("rand");
            step();
        end
        idle();
        step();
        check_all("final");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
